uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Receive-side counterpart of the team's UART transmitter. Oversamples the asynchronous serial line with a fixed clocks-per-bit count and detects the start bit. Samples 8 data bits LSB-first at mid-bit, checks the stop bit, and presents each received byte with a one-cycle valid strobe. Sits between the board RX pin and the SPI/UART configuration logic that consumes command bytes.

## Interface
- CLKS_PER_BIT, 87, system clocks per serial bit (10 MHz / 115200); legal range 4..65535
- i_Clk  input  1  system clock, all logic on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Rx_Serial  input  1  asynchronous serial line, idle high
- o_Rx_DV  output  1  one-cycle strobe: o_Rx_Byte holds a newly received valid byte
- o_Rx_Byte  output  8  last valid received byte, LSB = first data bit on the line
- o_Rx_Frame_Err  output  1  one-cycle strobe: stop bit sampled low
- o_Rx_Busy  output  1  high whenever the FSM is not in s_IDLE
- o_Rx_Parity_Err  output  1  present only with UART_RX_PARITY_EN; see Configuration

## Operation
- Input synchronizer: 2 flip-flops on i_Rx_Serial; both reset to 1. r_Rx is the second stage and is the only signal the FSM reads.
- Counter r_Clk_Count is wide enough for CLKS_PER_BIT-1. r_Bit_Index is 3 bits. r_Shift is 8 bits.
- States: s_IDLE, s_RX_START_BIT, s_RX_DATA_BITS, s_RX_STOP_BIT, s_CLEANUP (plus s_RX_PARITY_BIT with macro).
- s_IDLE: r_Clk_Count=0, r_Bit_Index=0. r_Rx==0 -> s_RX_START_BIT.
- s_RX_START_BIT: count up; when r_Clk_Count==(CLKS_PER_BIT-1)/2:
  - r_Rx==0 -> clear counter, go to s_RX_DATA_BITS.
  - r_Rx==1 (glitch) -> s_IDLE with no strobes.
- s_RX_DATA_BITS: count to CLKS_PER_BIT-1, then:
  - clear counter and store r_Rx into r_Shift[r_Bit_Index].
  - r_Bit_Index<7: increment index.
  - r_Bit_Index==7: reset index to 0 and go to s_RX_STOP_BIT (or s_RX_PARITY_BIT).
- s_RX_STOP_BIT: count to CLKS_PER_BIT-1, then go to s_CLEANUP:
  - r_Rx==1: o_Rx_Byte<=r_Shift, o_Rx_DV<=1.
  - r_Rx==0: o_Rx_Frame_Err<=1; o_Rx_Byte is left unchanged.
- s_CLEANUP: one cycle; clears strobes; -> s_IDLE.
- o_Rx_DV, o_Rx_Frame_Err and o_Rx_Parity_Err are never high together and never high for more than one cycle.
- A line held low continuously causes repeated frame errors. There is no lockout. Each new start is detected only after s_CLEANUP.
- Reset is valid in any state. On the next edge: state s_IDLE, counters 0, sync FFs 1, r_Shift 0x00. A partial frame is discarded with no strobe.

## Timing
- Reset values: o_Rx_DV=0, o_Rx_Byte=0x00, o_Rx_Frame_Err=0, o_Rx_Busy=0, o_Rx_Parity_Err=0.
- Synchronizer latency: 2 cycles from pin to r_Rx. The FSM leaves s_IDLE 1 cycle later.
- Data bits are sampled at mid-bit: start midpoint + k*CLKS_PER_BIT cycles, k=1..8. The stop bit is sampled at k=9 (k=10 with parity).
- o_Rx_DV / o_Rx_Frame_Err rise the cycle after the stop sample. They stay high exactly 1 cycle, in s_CLEANUP.
- A byte is ready within the stop-bit period; back-to-back frames with zero idle bits are received without loss.
- o_Rx_Busy is registered from state, so it is high from the cycle after start detection through s_CLEANUP.

## Configuration
- UART_RX_PARITY_EN defined:
  - s_RX_PARITY_BIT sits between data and stop, counting CLKS_PER_BIT-1 and sampling r_Rx.
  - Even parity: the error condition is (^r_Shift) != sampled bit.
  - On the stop sample, if parity failed: o_Rx_Parity_Err pulses for 1 cycle instead of o_Rx_DV, and o_Rx_Byte is not updated.
  - Frame error takes priority over parity error.
- Undefined: no parity state. The o_Rx_Parity_Err port is absent. The frame is 10 bits.

## Test plan
- CLKS_PER_BIT=16, send 0xA5, 1 stop -> single o_Rx_DV pulse inside stop bit, o_Rx_Byte=0xA5, Frame_Err never high.
- Back-to-back 0x00 then 0xFF, zero idle -> two DV pulses exactly 10*16 cycles apart, bytes 0x00 then 0xFF.
- Line low for 3 cycles then high, CLKS_PER_BIT=16 -> FSM returns to s_IDLE, no strobe, o_Rx_Byte unchanged.
- Send 0x5A with stop bit low -> o_Rx_Frame_Err 1-cycle pulse, no DV, o_Rx_Byte keeps prior value 0xA5.
- Assert i_Rst mid-data-bit 4 of 0x3C:
  - next cycle all outputs at reset values and o_Rx_Busy=0.
  - after release, a full 0x3C frame -> DV with 0x3C.
- With UART_RX_PARITY_EN: 0x01 with parity bit 0 -> o_Rx_Parity_Err pulse, no DV. 0x01 with parity bit 1 -> DV, byte 0x01.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Serial-receive bundle: RX pin in, received byte and status strobes out.
// Parity error line exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_fsm_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Busy;
`ifdef UART_RX_PARITY_EN
    logic       o_Rx_Parity_Err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        input  o_Rx_Parity_Err,
`endif
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Frame_Err,
        input  o_Rx_Busy
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        output o_Rx_Parity_Err,
`endif
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
        output o_Rx_Busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits LSB-first, 1 stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    uart_rx_fsm_if.slave rx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        s_IDLE,
        s_RX_START_BIT,
        s_RX_DATA_BITS,
`ifdef UART_RX_PARITY_EN
        s_RX_PARITY_BIT,
`endif
        s_RX_STOP_BIT,
        s_CLEANUP
    } state_t;

    state_t        r_State;
    state_t        w_State;
    logic          r_Rx_Meta;
    logic          r_Rx;
    logic [CW-1:0] r_Clk_Count;
    logic [CW-1:0] w_Clk_Count;
    logic [2:0]    r_Bit_Index;
    logic [2:0]    w_Bit_Index;
    logic [7:0]    r_Shift;
    logic [7:0]    w_Shift;
    logic [7:0]    r_Byte;
    logic [7:0]    w_Byte;
    logic          r_Dv;
    logic          w_Dv;
    logic          r_Ferr;
    logic          w_Ferr;
`ifdef UART_RX_PARITY_EN
    logic          r_Par;
    logic          w_Par;
    logic          r_Perr;
    logic          w_Perr;
`endif

    // Two-stage synchronizer; idle-high reset avoids a false start bit.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Rx_Meta <= 1'b1;
            r_Rx      <= 1'b1;
        end else begin
            r_Rx_Meta <= rx.i_Rx_Serial;
            r_Rx      <= r_Rx_Meta;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State     <= s_IDLE;
            r_Clk_Count <= '0;
            r_Bit_Index <= '0;
            r_Shift     <= '0;
            r_Byte      <= '0;
            r_Dv        <= 1'b0;
            r_Ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Par       <= 1'b0;
            r_Perr      <= 1'b0;
`endif
        end else begin
            r_State     <= w_State;
            r_Clk_Count <= w_Clk_Count;
            r_Bit_Index <= w_Bit_Index;
            r_Shift     <= w_Shift;
            r_Byte      <= w_Byte;
            r_Dv        <= w_Dv;
            r_Ferr      <= w_Ferr;
`ifdef UART_RX_PARITY_EN
            r_Par       <= w_Par;
            r_Perr      <= w_Perr;
`endif
        end
    end

    always_comb begin
        w_State     = r_State;
        w_Clk_Count = r_Clk_Count;
        w_Bit_Index = r_Bit_Index;
        w_Shift     = r_Shift;
        w_Byte      = r_Byte;
        w_Dv        = 1'b0;
        w_Ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_Par       = r_Par;
        w_Perr      = 1'b0;
`endif
        unique case (r_State)
            s_IDLE: begin
                w_Clk_Count = '0;
                w_Bit_Index = '0;
                if (!r_Rx)
                    w_State = s_RX_START_BIT;
            end
            s_RX_START_BIT: begin
                if (r_Clk_Count == HALF) begin
                    w_Clk_Count = '0;
                    w_State = r_Rx ? s_IDLE : s_RX_DATA_BITS;
                end else begin
                    w_Clk_Count = r_Clk_Count + 1'b1;
                end
            end
            s_RX_DATA_BITS: begin
                if (r_Clk_Count != LAST) begin
                    w_Clk_Count = r_Clk_Count + 1'b1;
                end else begin
                    w_Clk_Count = '0;
                    w_Shift[r_Bit_Index] = r_Rx;
                    if (r_Bit_Index != 3'd7) begin
                        w_Bit_Index = r_Bit_Index + 1'b1;
                    end else begin
                        w_Bit_Index = '0;
`ifdef UART_RX_PARITY_EN
                        w_State = s_RX_PARITY_BIT;
`else
                        w_State = s_RX_STOP_BIT;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            s_RX_PARITY_BIT: begin
                if (r_Clk_Count != LAST) begin
                    w_Clk_Count = r_Clk_Count + 1'b1;
                end else begin
                    w_Clk_Count = '0;
                    w_Par = r_Rx;
                    w_State = s_RX_STOP_BIT;
                end
            end
`endif
            s_RX_STOP_BIT: begin
                if (r_Clk_Count != LAST) begin
                    w_Clk_Count = r_Clk_Count + 1'b1;
                end else begin
                    w_Clk_Count = '0;
                    w_State = s_CLEANUP;
                    if (!r_Rx) begin
                        w_Ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^r_Shift) != r_Par) begin
                        w_Perr = 1'b1;
`endif
                    end else begin
                        w_Byte = r_Shift;
                        w_Dv = 1'b1;
                    end
                end
            end
            s_CLEANUP: begin
                w_State = s_IDLE;
            end
            default: begin
                w_State = s_IDLE;
            end
        endcase
    end

    assign rx.o_Rx_DV        = r_Dv;
    assign rx.o_Rx_Byte      = r_Byte;
    assign rx.o_Rx_Frame_Err = r_Ferr;
    assign rx.o_Rx_Busy      = (r_State != s_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.o_Rx_Parity_Err = r_Perr;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at 16 clocks per bit.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fsm;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int DV_OFS = 171;
    localparam int FRAME  = 176;
`else
    localparam int DV_OFS = 155;
    localparam int FRAME  = 160;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_fsm_if rx_if ();

    uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .rx    (rx_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int start_cyc;
    int dv_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int dv_cyc = 0;
    int dv_prev_cyc = 0;
    int ferr_cyc = 0;
    int pulse_err = 0;
    logic [7:0] byte_last = 8'h00;
    logic [7:0] byte_prev = 8'h00;
    logic dv_q = 1'b0;
    logic ferr_q = 1'b0;
    logic perr_now;
    logic perr_q = 1'b0;

`ifdef UART_RX_PARITY_EN
    assign perr_now = rx_if.o_Rx_Parity_Err;
`else
    assign perr_now = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses, records timing, flags long or overlapping pulses.
    always @(negedge clk) begin
        dv_q   <= rx_if.o_Rx_DV;
        ferr_q <= rx_if.o_Rx_Frame_Err;
        perr_q <= perr_now;
        if (rx_if.o_Rx_DV) begin
            dv_cnt      <= dv_cnt + 1;
            dv_prev_cyc <= dv_cyc;
            dv_cyc      <= cyc;
            byte_prev   <= byte_last;
            byte_last   <= rx_if.o_Rx_Byte;
        end
        if (rx_if.o_Rx_Frame_Err) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
        if (perr_now)
            perr_cnt <= perr_cnt + 1;
        if ((rx_if.o_Rx_DV && dv_q) ||
            (rx_if.o_Rx_Frame_Err && ferr_q) ||
            (perr_now && perr_q))
            pulse_err <= pulse_err + 1;
        if (int'(rx_if.o_Rx_DV) + int'(rx_if.o_Rx_Frame_Err) +
            int'(perr_now) > 1)
            pulse_err <= pulse_err + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        rx_if.i_Rx_Serial = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_if.i_Rx_Serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller sits 1 time unit after a rising edge.
    task automatic send(input logic [7:0] d,
                        input logic stop,
                        input logic par);
        start_cyc = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++)
            hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par);
`else
        if (par) begin end
`endif
        hold_bit(stop);
    endtask

    int d0, f0, g0;

    initial begin
        rx_if.i_Rx_Serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_dv", 32'(rx_if.o_Rx_DV), 0);
        check("rst_byte", 32'(rx_if.o_Rx_Byte), 0);
        check("rst_ferr", 32'(rx_if.o_Rx_Frame_Err), 0);
        check("rst_busy", 32'(rx_if.o_Rx_Busy), 0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", 32'(rx_if.o_Rx_Parity_Err), 0);
`endif
        rst = 1'b0;
        idle(2 * CPB);

        // back-to-back 0x00, 0xFF
        d0 = dv_cnt; f0 = ferr_cnt;
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        idle(2 * CPB);
        check("b2b_dv_cnt", dv_cnt - d0, 2);
        check("b2b_byte0", 32'(byte_prev), 32'h00);
        check("b2b_byte1", 32'(byte_last), 32'hFF);
        check("b2b_spacing", dv_cyc - dv_prev_cyc, FRAME);
        check("b2b_ferr", ferr_cnt - f0, 0);

        // 3-cycle glitch
        d0 = dv_cnt; f0 = ferr_cnt;
        g0 = cyc;
        rx_if.i_Rx_Serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_if.i_Rx_Serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("glitch_busy_hi", 32'(rx_if.o_Rx_Busy), 1);
        idle(2 * CPB);
        check("glitch_busy_lo", 32'(rx_if.o_Rx_Busy), 0);
        check("glitch_dv", dv_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_byte", 32'(rx_if.o_Rx_Byte), 32'hFF);

        // 0xA5 good frame
        d0 = dv_cnt; f0 = ferr_cnt;
        send(8'hA5, 1'b1, 1'b0);
        idle(2 * CPB);
        check("a5_dv_cnt", dv_cnt - d0, 1);
        check("a5_byte", 32'(byte_last), 32'hA5);
        check("a5_dv_ofs", dv_cyc - start_cyc, DV_OFS);
        check("a5_ferr", ferr_cnt - f0, 0);

        // 0x5A with stop bit low
        d0 = dv_cnt; f0 = ferr_cnt;
        send(8'h5A, 1'b0, 1'b0);
        idle(3 * CPB);
        check("ferr_cnt", ferr_cnt - f0, 1);
        check("ferr_ofs", ferr_cyc - start_cyc, DV_OFS);
        check("ferr_dv", dv_cnt - d0, 0);
        check("ferr_byte", 32'(rx_if.o_Rx_Byte), 32'hA5);

        // reset in the middle of data bit 4 of 0x3C
        d0 = dv_cnt; f0 = ferr_cnt;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++)
            hold_bit(i >= 2);
        rx_if.i_Rx_Serial = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_dv", 32'(rx_if.o_Rx_DV), 0);
        check("mid_rst_byte", 32'(rx_if.o_Rx_Byte), 0);
        check("mid_rst_ferr", 32'(rx_if.o_Rx_Frame_Err), 0);
        check("mid_rst_busy", 32'(rx_if.o_Rx_Busy), 0);
        rst = 1'b0;
        idle(2 * CPB);
        check("mid_rst_no_dv", dv_cnt - d0, 0);
        send(8'h3C, 1'b1, 1'b0);
        idle(2 * CPB);
        check("post_rst_dv", dv_cnt - d0, 1);
        check("post_rst_byte", 32'(byte_last), 32'h3C);
        check("post_rst_ferr", ferr_cnt - f0, 0);

`ifdef UART_RX_PARITY_EN
        d0 = dv_cnt;
        send(8'h01, 1'b1, 1'b0);
        idle(2 * CPB);
        check("par_bad_perr", perr_cnt, 1);
        check("par_bad_dv", dv_cnt - d0, 0);
        check("par_bad_byte", 32'(rx_if.o_Rx_Byte), 32'h3C);
        send(8'h01, 1'b1, 1'b1);
        idle(2 * CPB);
        check("par_ok_dv", dv_cnt - d0, 1);
        check("par_ok_byte", 32'(byte_last), 32'h01);
        check("par_ok_perr", perr_cnt, 1);
`endif

        check("pulse_shape", pulse_err, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
